accel_spi_reader: RTL and testbench



---
 rtl/accel_spi_pkg.sv | 27 ++
 rtl/accel_spi_reader_if.sv | 23 ++
 rtl/spi_xfer16.sv | 79 +++++++
 rtl/accel_spi_reader.sv | 134 +++++++++++++
 tb/tb_accel_spi_reader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_spi_pkg.sv
// Shared types and constants for the accelerometer SPI reader: FSM states,
// default register map and command-byte construction.
package accel_spi_pkg;

    typedef enum logic [2:0] {
        StStartup,
        StInitWr,
        StIdle,
        StRdX,
        StRdY,
        StUpdate
    } state_e;

    localparam logic [5:0] DefaultInitAddr = 6'h20;
    localparam logic [7:0] DefaultInitData = 8'h77;
    localparam logic [5:0] DefaultXAddr    = 6'h29;
    localparam logic [5:0] DefaultYAddr    = 6'h2B;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    // Command byte: R/W flag, address-increment bit (always 0), 6-bit register address.
    function automatic logic [7:0] build_cmd(input logic rw, input logic [5:0] addr);
        return {rw, 1'b0, addr};
    endfunction

endpackage

// File: rtl/accel_spi_reader_if.sv
// Accelerometer pin bundle plus the X/Y sample outputs handed to game logic.
interface accel_spi_reader_if;

    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] accel_data_x;
    logic [7:0] accel_data_y;
    logic       data_valid;
    logic       busy;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, accel_data_x, accel_data_y, data_valid, busy,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, accel_data_x, accel_data_y, data_valid, busy,
        output spi_miso
    );

endinterface

// File: rtl/spi_xfer16.sv
// Single 16-bit SPI mode-3 frame engine: lead-in, 16 bit periods, tail.
// done pulses in the final tail cycle so CS rises on the same edge the caller moves on.
module spi_xfer16 #(
    parameter int unsigned CLK_DIV = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tx_word,
    output logic [15:0] rx_word,
    output logic        done,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int unsigned    DivW      = $clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [5:0]     LastPhase = 6'd33;
    localparam logic [5:0]     LastBitHi = 6'd32;

    // Phase 0 is the lead-in, odd phases 1..31 are SCLK-low, even 2..32 SCLK-high, 33 the tail.
    logic            active_q;
    logic [5:0]      phase_q;
    logic [DivW-1:0] div_q;
    logic [15:0]     tx_q;
    logic [15:0]     rx_q;
    logic            sclk_q;
    logic            cs_n_q;
    logic            mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= '0;
            div_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else if (!active_q) begin
            if (start) begin
                active_q <= 1'b1;
                cs_n_q   <= 1'b0;
                phase_q  <= '0;
                div_q    <= '0;
                tx_q     <= tx_word;
            end
        end else if (div_q != DivLast) begin
            div_q <= div_q + 1'b1;
        end else begin
            div_q   <= '0;
            phase_q <= phase_q + 6'd1;
            if (phase_q == LastPhase) begin
                active_q <= 1'b0;
                cs_n_q   <= 1'b1;
                mosi_q   <= 1'b0;
            end else if (phase_q == LastBitHi) begin
                sclk_q <= 1'b1;
            end else if (!phase_q[0]) begin
                sclk_q <= 1'b0;
                mosi_q <= tx_q[15];
                tx_q   <= {tx_q[14:0], 1'b0};
            end else begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[14:0], miso};
            end
        end
    end

    assign done    = active_q && (div_q == DivLast) && (phase_q == LastPhase);
    assign rx_word = rx_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/accel_spi_reader.sv
// Configures the accelerometer once after reset, then polls X and Y high bytes and
// publishes them as a matched pair with a one-cycle data_valid strobe.
module accel_spi_reader
    import accel_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 9,
    parameter int unsigned STARTUP_CYCLES = 36000,
    parameter int unsigned POLL_PERIOD    = 360000,
    parameter logic [5:0]  INIT_ADDR      = DefaultInitAddr,
    parameter logic [7:0]  INIT_DATA      = DefaultInitData,
    parameter logic [5:0]  X_ADDR         = DefaultXAddr,
    parameter logic [5:0]  Y_ADDR         = DefaultYAddr
) (
    input logic                pixel_clk,
    input logic                rst_n,
    accel_spi_reader_if.master bus
);

    localparam logic [31:0] StartupLast = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] PollLast    = 32'(POLL_PERIOD - 1);
    localparam logic [31:0] GapLoad     = 32'(2 * CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [31:0] startup_q;
    logic [31:0] poll_q;
    logic        poll_en_q;
    logic        pending_q;
    logic        launched_q;
    logic [31:0] gap_q;
    logic [7:0]  shadow_q, x_q, y_q;

    logic        start, done, poll_expire, load_shadow, load_out, data_valid;
    logic [15:0] tx_word, rx_word;
    logic        unused_rx_cmd;

    assign poll_expire   = poll_en_q && (poll_q == PollLast);
    assign unused_rx_cmd = ^rx_word[15:8];

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) state_q <= StStartup;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStartup: if (startup_q == StartupLast) state_d = StInitWr;
            StInitWr:  if (done) state_d = StIdle;
            StIdle:    if (pending_q || poll_expire) state_d = StRdX;
            StRdX:     if (done) state_d = StRdY;
            StRdY:     if (done) state_d = StUpdate;
            StUpdate:  state_d = StIdle;
            default:   state_d = StStartup;
        endcase
    end

    // A frame is launched once per transfer state, after the minimum CS-high gap.
    always_comb begin
        start       = 1'b0;
        tx_word     = '0;
        load_shadow = 1'b0;
        load_out    = 1'b0;
        data_valid  = 1'b0;
        unique case (state_q)
            StInitWr: begin
                tx_word = {build_cmd(CMD_WRITE, INIT_ADDR), INIT_DATA};
                start   = !launched_q && (gap_q == '0);
            end
            StRdX: begin
                tx_word     = {build_cmd(CMD_READ, X_ADDR), 8'h00};
                start       = !launched_q && (gap_q == '0);
                load_shadow = done;
            end
            StRdY: begin
                tx_word  = {build_cmd(CMD_READ, Y_ADDR), 8'h00};
                start    = !launched_q && (gap_q == '0);
                load_out = done;
            end
            StUpdate: data_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            startup_q  <= '0;
            poll_q     <= '0;
            poll_en_q  <= 1'b0;
            pending_q  <= 1'b0;
            launched_q <= 1'b0;
            gap_q      <= '0;
            shadow_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            if (state_q == StStartup) startup_q <= startup_q + 32'd1;
            if (start)     launched_q <= 1'b1;
            else if (done) launched_q <= 1'b0;
            if (done)               gap_q <= GapLoad;
            else if (gap_q != '0)   gap_q <= gap_q - 32'd1;
            if ((state_q == StInitWr) && done) poll_en_q <= 1'b1;
            if (poll_en_q) poll_q <= poll_expire ? '0 : poll_q + 32'd1;
            // Expiries outside IDLE collapse into a single pending read.
            if (state_q == StIdle)  pending_q <= 1'b0;
            else if (poll_expire)   pending_q <= 1'b1;
            if (load_shadow) shadow_q <= rx_word[7:0];
            if (load_out) begin
                x_q <= shadow_q;
                y_q <= rx_word[7:0];
            end
        end
    end

    spi_xfer16 #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .clk     (pixel_clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_word (tx_word),
        .rx_word (rx_word),
        .done    (done),
        .sclk    (bus.spi_sclk),
        .cs_n    (bus.spi_cs_n),
        .mosi    (bus.spi_mosi),
        .miso    (bus.spi_miso)
    );

    assign bus.accel_data_x = x_q;
    assign bus.accel_data_y = y_q;
    assign bus.data_valid   = data_valid;
    assign bus.busy         = ~bus.spi_cs_n;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: two instances (normal and short poll period) driven by a
// mode-3 slave model that scores every frame and every published X/Y pair.
module tb_accel_spi_reader;

    localparam int unsigned CD  = 2;
    localparam int unsigned SU  = 20;
    localparam int unsigned PA  = 400;
    localparam int unsigned PB  = 50;
    localparam int          FRAME_LEN = 34 * CD;
    localparam int          GAP_MIN   = 2 * CD;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] miso_r;
    logic [7:0] x_a, y_a;
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    accel_spi_reader_if bus_a ();
    accel_spi_reader_if bus_b ();
    assign bus_a.spi_miso = miso_r[0];
    assign bus_b.spi_miso = miso_r[1];

    accel_spi_reader #(.CLK_DIV(CD), .STARTUP_CYCLES(SU), .POLL_PERIOD(PA)) dut_a (
        .pixel_clk (clk),
        .rst_n     (rst_a),
        .bus       (bus_a)
    );

    accel_spi_reader #(.CLK_DIV(CD), .STARTUP_CYCLES(SU), .POLL_PERIOD(PB)) dut_b (
        .pixel_clk (clk),
        .rst_n     (rst_b),
        .bus       (bus_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave + scoreboard state, one slot per DUT.
    logic        m_prev_cs[2], m_prev_sclk[2], m_prev_mosi[2];
    int          m_len[2], m_nbits[2], m_idx[2], m_gap[2], m_dv_cnt[2];
    logic [15:0] m_word[2], m_reply[2];
    logic [7:0]  m_last_x[2], m_last_y[2], m_held_x[2], m_held_y[2];

    task automatic mon_step(input int d, input logic rst, input logic cs_n, input logic sclk,
                            input logic mosi, input logic dv, input logic [7:0] ox,
                            input logic [7:0] oy);
        logic        exp_dv;
        logic        fell;
        logic [15:0] exp_word;
        exp_dv = 1'b0;
        fell   = m_prev_sclk[d] && !sclk;
        if (!rst) begin
            m_prev_cs[d] = 1'b1; m_prev_sclk[d] = 1'b1; m_prev_mosi[d] = 1'b0;
            m_idx[d] = 0; m_gap[d] = 0; m_nbits[d] = 0; m_len[d] = 0;
            m_last_x[d] = '0; m_last_y[d] = '0; m_held_x[d] = '0; m_held_y[d] = '0;
            miso_r[d] = 1'b0;
            return;
        end
        if (!cs_n) begin
            if (m_prev_cs[d]) begin
                if (m_idx[d] >= 2 && d == 1) chk("cs_gap_b2b", m_gap[d], GAP_MIN);
                else if (m_idx[d] >= 1)      chk("cs_gap_min", 32'(m_gap[d] >= GAP_MIN), 1);
                m_len[d] = 1; m_nbits[d] = 0; m_word[d] = '0;
                m_reply[d] = {8'($urandom), 8'h00};
            end else begin
                m_len[d]++;
                if (!m_prev_sclk[d] && sclk) begin
                    m_word[d] = {m_word[d][14:0], mosi};
                    m_nbits[d]++;
                    if (m_nbits[d] == 8) begin
                        if (d == 1)                   m_reply[d][7:0] = 8'($urandom);
                        else if (m_word[d][7:0] == 8'hA9) m_reply[d][7:0] = x_a;
                        else if (m_word[d][7:0] == 8'hAB) m_reply[d][7:0] = y_a;
                    end
                end else if (fell && m_nbits[d] < 16) begin
                    miso_r[d] = m_reply[d][15 - m_nbits[d]];
                end
                if (mosi !== m_prev_mosi[d]) chk("mosi_moves_on_sclk_fall", 32'(fell), 1);
            end
        end else if (!m_prev_cs[d]) begin
            chk("cs_low_len", m_len[d], FRAME_LEN);
            chk("bit_count", m_nbits[d], 16);
            if (m_idx[d] == 0)          exp_word = 16'h2077;
            else if (m_idx[d] % 2 == 1) exp_word = 16'hA900;
            else                        exp_word = 16'hAB00;
            chk("mosi_word", m_word[d], exp_word);
            if (m_idx[d] > 0 && m_idx[d] % 2 == 1) m_last_x[d] = m_reply[d][7:0];
            if (m_idx[d] > 0 && m_idx[d] % 2 == 0) begin
                m_last_y[d] = m_reply[d][7:0];
                exp_dv = 1'b1;
            end
            m_idx[d]++;
            m_gap[d] = 1;
        end else begin
            m_gap[d]++;
        end
        if (exp_dv) begin
            m_held_x[d] = m_last_x[d];
            m_held_y[d] = m_last_y[d];
            m_dv_cnt[d]++;
        end
        chk("data_valid", 32'(dv), 32'(exp_dv));
        chk("x_out", ox, m_held_x[d]);
        chk("y_out", oy, m_held_y[d]);
        m_prev_cs[d] = cs_n; m_prev_sclk[d] = sclk; m_prev_mosi[d] = mosi;
    endtask

    always @(posedge clk) begin
        #1;
        mon_step(0, rst_a, bus_a.spi_cs_n, bus_a.spi_sclk, bus_a.spi_mosi, bus_a.data_valid,
                 bus_a.accel_data_x, bus_a.accel_data_y);
        mon_step(1, rst_b, bus_b.spi_cs_n, bus_b.spi_sclk, bus_b.spi_mosi, bus_b.data_valid,
                 bus_b.accel_data_x, bus_b.accel_data_y);
    end

    task automatic wait_dv_a();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            if (bus_a.data_valid) return;
        end
        chk("data_valid_timeout", 0, 1);
    endtask

    task automatic wait_cs_fall_a();
        logic prev;
        prev = bus_a.spi_cs_n;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            if (prev && !bus_a.spi_cs_n) return;
            prev = bus_a.spi_cs_n;
        end
        chk("cs_fall_timeout", 0, 1);
    endtask

    task automatic count_startup_a(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            cnt++;
            if (!bus_a.spi_cs_n) return;
        end
    endtask

    typedef struct {
        logic [7:0] reg_x;
        logic [7:0] reg_y;
        logic [7:0] exp_x;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          cnt;
        logic [31:0] r;
        vecs[0] = '{8'hF3, 8'h1C, 8'hF3, 8'h1C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
        vecs[3] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
        for (int i = 4; i < 8; i++) begin
            r = $urandom;
            vecs[i] = '{r[7:0], r[15:8], r[7:0], r[15:8]};
        end
        x_a = 8'h00; y_a = 8'h00;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_sclk", bus_a.spi_sclk, 1);
        chk("rst_cs_n", bus_a.spi_cs_n, 1);
        chk("rst_mosi", bus_a.spi_mosi, 0);
        chk("rst_x", bus_a.accel_data_x, 0);
        chk("rst_y", bus_a.accel_data_y, 0);
        chk("rst_dv", bus_a.data_valid, 0);
        chk("rst_busy", bus_a.busy, 0);

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        count_startup_a(cnt);
        chk("startup_edges", cnt, SU + 1);

        for (int i = 0; i < 8; i++) begin
            x_a = vecs[i].reg_x;
            y_a = vecs[i].reg_y;
            wait_dv_a();
            chk("vec_x", bus_a.accel_data_x, vecs[i].exp_x);
            chk("vec_y", bus_a.accel_data_y, vecs[i].exp_y);
        end

        // X changes while Y is being read: the pair published next still carries the old X.
        x_a = 8'h11; y_a = 8'h22;
        wait_dv_a();
        chk("pair_x", bus_a.accel_data_x, 8'h11);
        wait_cs_fall_a();
        wait_cs_fall_a();
        x_a = 8'h05;
        wait_dv_a();
        chk("old_x_kept", bus_a.accel_data_x, 8'h11);
        chk("old_pair_y", bus_a.accel_data_y, 8'h22);
        wait_dv_a();
        chk("new_x", bus_a.accel_data_x, 8'h05);

        // Reset at bit 9 of the Y frame.
        wait_cs_fall_a();
        wait_cs_fall_a();
        for (int i = 0; i < 200 && m_nbits[0] != 9; i++) begin
            @(posedge clk); #2;
        end
        chk("reached_bit9", m_nbits[0], 9);
        chk("busy_in_frame", bus_a.busy, 1);
        rst_a = 1'b0;
        #1;
        chk("mid_rst_cs_n", bus_a.spi_cs_n, 1);
        chk("mid_rst_sclk", bus_a.spi_sclk, 1);
        chk("mid_rst_x", bus_a.accel_data_x, 0);
        chk("mid_rst_y", bus_a.accel_data_y, 0);
        chk("mid_rst_busy", bus_a.busy, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        count_startup_a(cnt);
        chk("restart_edges", cnt, SU + 1);
        x_a = 8'h3C; y_a = 8'hC3;
        wait_dv_a();
        chk("after_rst_x", bus_a.accel_data_x, 8'h3C);
        chk("after_rst_y", bus_a.accel_data_y, 8'hC3);

        chk("b_pairs_seen", 32'(m_dv_cnt[1] > 10), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        m_dv_cnt[0] = 0;
        m_dv_cnt[1] = 0;
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
